// File: rtl/traffic_request_conditioner.sv
// rtl/traffic_request_conditioner.sv - synchronizes, debounces and arbitrates intersection requests
// Sensors are debounced, ped buttons latch until their approach goes green, emergencies lock one axis.
module traffic_request_conditioner #(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int EMERG_QUAL      = 2,
   parameter int EMERG_HOLD      = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] sensor_raw,
   input  logic [3:0] ped_raw,
   input  logic [3:0] emergency_raw,
   input  logic [1:0] TL1,
   input  logic [1:0] TL2,
   input  logic [1:0] TL3,
   input  logic [1:0] TL4,
   output logic [3:0] sensor_q,
   output logic [3:0] ped_req,
   output logic [3:0] emergency_q,
   output logic [1:0] emergency_lock,
   output logic       emergency_conflict
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'b00,
      ST_LOCK13 = 2'b01,
      ST_LOCK24 = 2'b10
   } state_t;

   localparam logic [3:0] SENS_LAST = 4'(DEBOUNCE_CYCLES - 1);
   localparam logic [3:0] QUAL_LAST = 4'(EMERG_QUAL - 1);
   localparam logic [3:0] HOLD_LAST = 4'(EMERG_HOLD - 1);

   // Bit layout of the synchronizer chain: [3:0] sensors, [7:4] ped, [11:8] emergency.
   logic [11:0] sync1_q, sync1_d;
   logic [11:0] sync2_q, sync2_d;
   logic [3:0]  ped_prev_q, ped_prev_d;
   logic [3:0]  sensor_d;
   logic [3:0]  ped_req_q, ped_req_d;
   logic [3:0]  eqi_q, eqi_d;
   logic [3:0]  sens_cnt_q [4];
   logic [3:0]  sens_cnt_d [4];
   logic [3:0]  emerg_cnt_q [4];
   logic [3:0]  emerg_cnt_d [4];
   state_t      state_q, state_d;
   logic [3:0]  tl_green;
   logic        ax13, ax24;

   assign tl_green = {TL4 == 2'b01, TL3 == 2'b01, TL2 == 2'b01, TL1 == 2'b01};
   assign ax13     = eqi_q[0] | eqi_q[2];
   assign ax24     = eqi_q[1] | eqi_q[3];

   always_comb begin
      sync1_d    = {emergency_raw, ped_raw, sensor_raw};
      sync2_d    = sync1_q;
      ped_prev_d = sync2_q[7:4];
      sensor_d   = sensor_q;
      ped_req_d  = ped_req_q;
      eqi_d      = eqi_q;
      for (int i = 0; i < 4; i++) begin
         sens_cnt_d[i]  = '0;
         emerg_cnt_d[i] = '0;
         if (sync2_q[i] != sensor_q[i]) begin
            if (sens_cnt_q[i] == SENS_LAST) sensor_d[i] = sync2_q[i];
            else sens_cnt_d[i] = sens_cnt_q[i] + 4'd1;
         end
         // Qualification uses the short threshold, release the long one.
         if (sync2_q[8+i] != eqi_q[i]) begin
            if (emerg_cnt_q[i] == (eqi_q[i] ? HOLD_LAST : QUAL_LAST)) eqi_d[i] = sync2_q[8+i];
            else emerg_cnt_d[i] = emerg_cnt_q[i] + 4'd1;
         end
         if (tl_green[i]) ped_req_d[i] = 1'b0;
         else if (sync2_q[4+i] && !ped_prev_q[i]) ped_req_d[i] = 1'b1;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (ax13) state_d = ST_LOCK13;
            else if (ax24) state_d = ST_LOCK24;
         end
         ST_LOCK13: begin
            if (!ax13) state_d = ax24 ? ST_LOCK24 : ST_IDLE;
         end
         ST_LOCK24: begin
            if (!ax24) state_d = ax13 ? ST_LOCK13 : ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_q     <= '0;
         sync2_q     <= '0;
         ped_prev_q  <= '0;
         sensor_q    <= '0;
         ped_req_q   <= '0;
         eqi_q       <= '0;
         sens_cnt_q  <= '{default: '0};
         emerg_cnt_q <= '{default: '0};
         state_q     <= ST_IDLE;
      end else begin
         sync1_q     <= sync1_d;
         sync2_q     <= sync2_d;
         ped_prev_q  <= ped_prev_d;
         sensor_q    <= sensor_d;
         ped_req_q   <= ped_req_d;
         eqi_q       <= eqi_d;
         sens_cnt_q  <= sens_cnt_d;
         emerg_cnt_q <= emerg_cnt_d;
         state_q     <= state_d;
      end
   end

   assign ped_req            = ped_req_q;
   assign emergency_lock     = state_q;
   assign emergency_q        = {(state_q == ST_LOCK24) & eqi_q[3], (state_q == ST_LOCK13) & eqi_q[2],
                                (state_q == ST_LOCK24) & eqi_q[1], (state_q == ST_LOCK13) & eqi_q[0]};
   assign emergency_conflict = ((state_q == ST_LOCK13) & ax24) | ((state_q == ST_LOCK24) & ax13);

endmodule
